// File: rtl/ch_est_pkg.sv
// Shared defaults and types for the channel-estimate ping-pong buffer.
package ch_est_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_N_SC  = 12;
  localparam int SC_IDX_W  = $clog2(DEF_N_SC);

  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] re;
    logic signed [DEF_WIDTH-1:0] im;
  } cplx_t;

  // Index width that never collapses to zero bits for tiny depths.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ch_est_buffer_if.sv
// Write (pair) and read (single) handshake bundle of the estimate buffer.
interface ch_est_buffer_if import ch_est_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_SC  = DEF_N_SC
) ();
  localparam int SW = idx_w(N_SC);

  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] h1_r, h1_i, h2_r, h2_i;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_h_r, rd_h_i;
  logic [SW-1:0]    rd_sc;
  logic             rd_last;

  modport master (
    output wr_valid, h1_r, h1_i, h2_r, h2_i, rd_ready,
    input  wr_ready, rd_valid, rd_h_r, rd_h_i, rd_sc, rd_last
  );
  modport slave (
    input  wr_valid, h1_r, h1_i, h2_r, h2_i, rd_ready,
    output wr_ready, rd_valid, rd_h_r, rd_h_i, rd_sc, rd_last
  );
endinterface

// File: rtl/ch_est_bank.sv
// One symbol of complex estimates: pair-wide write port, single combinational read port.
module ch_est_bank import ch_est_pkg::*; #(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int N_SC  = DEF_N_SC,
  localparam int PW    = idx_w(N_SC/2),
  localparam int SW    = idx_w(N_SC)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PW-1:0]      widx,
  input  logic [2*WIDTH-1:0] wdata0,
  input  logic [2*WIDTH-1:0] wdata1,
  input  logic [SW-1:0]      ridx,
  output logic [2*WIDTH-1:0] rdata
);
  logic [N_SC-1:0][2*WIDTH-1:0] mem;

  // Storage is deliberately not reset; the full flags gate its visibility.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int p = 0; p < N_SC/2; p++) begin
        if (widx == PW'(p)) begin
          mem[2*p]   <= wdata0;
          mem[2*p+1] <= wdata1;
        end
      end
    end
  end

  assign rdata = mem[ridx];
endmodule

// File: rtl/ch_est_buffer.sv
// Two-bank ping-pong buffer: fills a symbol two estimates per cycle, drains it one per cycle.
module ch_est_buffer import ch_est_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_SC  = DEF_N_SC
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  output logic           err_ovf,
  ch_est_buffer_if.slave bus
);
  localparam int NP = N_SC/2;
  localparam int PW = idx_w(NP);
  localparam int SW = idx_w(N_SC);
  localparam logic [PW-1:0] WR_END = PW'(NP-1);
  localparam logic [SW-1:0] RD_END = SW'(N_SC-1);

  logic [1:0]                full;
  logic                      wr_bank, rd_bank;
  logic [PW-1:0]             wr_idx;
  logic [SW-1:0]             rd_idx;
  logic                      wr_acc, rd_acc, wr_done, rd_done;
  logic [1:0][2*WIDTH-1:0]   rd_word;

  assign wr_acc  = bus.wr_valid && !full[wr_bank];
  assign rd_acc  = bus.rd_ready &&  full[rd_bank];
  assign wr_done = wr_acc && (wr_idx == WR_END);
  assign rd_done = rd_acc && (rd_idx == RD_END);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ch_est_bank #(.WIDTH(WIDTH), .N_SC(N_SC)) u_bank (
      .clk    (clk),
      .we     (wr_acc && !flush && (wr_bank == 1'(b))),
      .widx   (wr_idx),
      .wdata0 ({bus.h1_r, bus.h1_i}),
      .wdata1 ({bus.h2_r, bus.h2_i}),
      .ridx   (rd_idx),
      .rdata  (rd_word[b])
    );
  end

  assign bus.wr_ready = !full[wr_bank];
  assign bus.rd_valid = full[rd_bank];
  assign {bus.rd_h_r, bus.rd_h_i} = rd_word[rd_bank];
  assign bus.rd_sc    = rd_idx;
  assign bus.rd_last  = full[rd_bank] && (rd_idx == RD_END);

  // Writer only ever completes an empty bank and reader only drains a full one,
  // so the two full-flag updates below never hit the same bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      err_ovf <= 1'b0;
    end else if (flush) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (bus.wr_valid && full[wr_bank]) err_ovf <= 1'b1;
      if (wr_acc) begin
        wr_idx <= wr_done ? '0 : wr_idx + PW'(1);
        if (wr_done) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end
      if (rd_acc) begin
        rd_idx <= rd_done ? '0 : rd_idx + SW'(1);
        if (rd_done) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end
      end
    end
  end
endmodule

// File: tb/tb_ch_est_buffer.sv
// Self-checking bench for ch_est_buffer: directed scenarios plus a randomized run against a symbol-queue model.
module tb_ch_est_buffer;
  import ch_est_pkg::*;
  localparam int W  = DEF_WIDTH;
  localparam int NS = DEF_N_SC;
  localparam int SW = SC_IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic err_ovf;
  int   checks = 0;
  int   errors = 0;

  ch_est_buffer_if #(.WIDTH(W), .N_SC(NS)) bus ();

  ch_est_buffer #(.WIDTH(W), .N_SC(NS)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .err_ovf (err_ovf),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: completed symbols waiting to be read (flattened), the partial symbol
  // being written, how many complete symbols are held, and the read position.
  cplx_t pend[$];
  cplx_t rdq[$];
  int    nsym;
  int    rpos;
  bit    m_err;

  task automatic m_clear();
    pend.delete();
    rdq.delete();
    nsym  = 0;
    rpos  = 0;
    m_err = 1'b0;
  endtask

  function automatic cplx_t mk(input int r, input int i);
    cplx_t c;
    c.re = W'(r);
    c.im = W'(i);
    return c;
  endfunction

  function automatic cplx_t rnd();
    cplx_t c;
    c.re = W'($urandom);
    c.im = W'($urandom);
    return c;
  endfunction

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic cyc(input bit wv, input cplx_t a, input cplx_t b, input bit rr, input bit fl);
    bit wacc, racc;
    bus.wr_valid = wv;
    bus.h1_r = a.re; bus.h1_i = a.im;
    bus.h2_r = b.re; bus.h2_i = b.im;
    bus.rd_ready = rr;
    flush = fl;
    wacc = wv && (nsym < 2);
    racc = rr && (nsym > 0);
    @(posedge clk);
    #1;
    if (fl) m_clear();
    else begin
      if (wv && !wacc) m_err = 1'b1;
      if (racc) begin
        void'(rdq.pop_front());
        rpos++;
        if (rpos == NS) begin rpos = 0; nsym--; end
      end
      if (wacc) begin
        pend.push_back(a);
        pend.push_back(b);
        if (pend.size() == NS) begin
          foreach (pend[j]) rdq.push_back(pend[j]);
          pend.delete();
          nsym++;
        end
      end
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    m_clear();
    bus.wr_valid = 1'b1; bus.rd_ready = 1'b0;
    bus.h1_r = '0; bus.h1_i = '0; bus.h2_r = '0; bus.h2_i = '0;
    #3;
    checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", bus.wr_ready); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
    checks++; if (bus.rd_sc !== SW'(0)) begin errors++; $display("FAIL reset_rd_sc got %0d exp 0", bus.rd_sc); end
    checks++; if (bus.rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got %b exp 0", bus.rd_last); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL reset_err_ovf got %b exp 0", err_ovf); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.wr_ready !== 1'b1 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL release_flags got wr_ready %b rd_valid %b exp 1 0", bus.wr_ready, bus.rd_valid); end
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_single_symbol();
    for (int k = 0; k < NS/2; k++) begin
      cyc(1'b1, mk(2*k, -2*k), mk(2*k+1, -(2*k+1)), 1'b1, 1'b0);
      checks++; if (bus.rd_valid !== (k == NS/2-1)) begin
        errors++; $display("FAIL single_fill_rd_valid pair %0d got %b exp %b", k, bus.rd_valid, (k == NS/2-1)); end
    end
    for (int i = 0; i < NS; i++) begin
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_sc !== SW'(i)) begin
        errors++; $display("FAIL single_rd_sc got valid %b sc %0d exp 1 %0d", bus.rd_valid, bus.rd_sc, i); end
      checks++; if (bus.rd_h_r !== W'(i) || bus.rd_h_i !== W'(-i)) begin
        errors++; $display("FAIL single_rd_data sc %0d got %0d/%0d exp %0d/%0d", i,
                            $signed(bus.rd_h_r), $signed(bus.rd_h_i), i, -i); end
      checks++; if (bus.rd_last !== (i == NS-1)) begin
        errors++; $display("FAIL single_rd_last sc %0d got %b exp %b", i, bus.rd_last, (i == NS-1)); end
      cyc(1'b0, mk(0, 0), mk(0, 0), 1'b1, 1'b0);
    end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b exp 0", bus.rd_valid); end
  endtask

  task automatic test_backpressure();
    cplx_t exp[$];
    cplx_t a, b;
    for (int k = 0; k < 18; k++) begin
      a = rnd(); b = rnd();
      checks++; if (bus.wr_ready !== (k < 12)) begin
        errors++; $display("FAIL bp_wr_ready pair %0d got %b exp %b", k, bus.wr_ready, (k < 12)); end
      if (k < 12) begin exp.push_back(a); exp.push_back(b); end
      cyc(1'b1, a, b, 1'b0, 1'b0);
      checks++; if (err_ovf !== (k >= 12)) begin
        errors++; $display("FAIL bp_err_ovf pair %0d got %b exp %b", k, err_ovf, (k >= 12)); end
    end
    for (int i = 0; i < 2*NS; i++) begin
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_sc !== SW'(i % NS)) begin
        errors++; $display("FAIL bp_rd_sc read %0d got valid %b sc %0d exp 1 %0d", i, bus.rd_valid, bus.rd_sc, i % NS); end
      checks++; if ({bus.rd_h_r, bus.rd_h_i} !== exp[i]) begin
        errors++; $display("FAIL bp_rd_data read %0d got %h exp %h", i, {bus.rd_h_r, bus.rd_h_i}, exp[i]); end
      cyc(1'b0, mk(0, 0), mk(0, 0), 1'b1, 1'b0);
    end
    checks++; if (bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1 || err_ovf !== 1'b1) begin
      errors++; $display("FAIL bp_after_drain got valid %b ready %b ovf %b exp 0 1 1", bus.rd_valid, bus.wr_ready, err_ovf); end
    cyc(1'b0, mk(0, 0), mk(0, 0), 1'b0, 1'b1);
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL bp_flush_ovf got %b exp 0", err_ovf); end
  endtask

  task automatic test_pingpong();
    cplx_t exp[$];
    cplx_t a, b;
    for (int k = 0; k < NS/2; k++) begin
      a = rnd(); b = rnd(); exp.push_back(a); exp.push_back(b);
      cyc(1'b1, a, b, 1'b0, 1'b0);
    end
    for (int i = 0; i < NS/2; i++) cyc(1'b0, mk(0, 0), mk(0, 0), 1'b1, 1'b0);
    for (int k = 0; k < NS/2; k++) begin
      checks++; if (bus.rd_sc !== SW'(NS/2 + k) || bus.wr_ready !== 1'b1) begin
        errors++; $display("FAIL pp_overlap step %0d got sc %0d ready %b exp %0d 1", k, bus.rd_sc, bus.wr_ready, NS/2 + k); end
      a = rnd(); b = rnd(); exp.push_back(a); exp.push_back(b);
      cyc(1'b1, a, b, 1'b1, 1'b0);
    end
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_sc !== SW'(0) || bus.wr_ready !== 1'b1) begin
      errors++; $display("FAIL pp_switch got valid %b sc %0d ready %b exp 1 0 1", bus.rd_valid, bus.rd_sc, bus.wr_ready); end
    for (int i = 0; i < NS; i++) begin
      checks++; if ({bus.rd_h_r, bus.rd_h_i} !== exp[NS+i]) begin
        errors++; $display("FAIL pp_bank1_data sc %0d got %h exp %h", i, {bus.rd_h_r, bus.rd_h_i}, exp[NS+i]); end
      cyc(1'b0, mk(0, 0), mk(0, 0), 1'b1, 1'b0);
    end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL pp_drained got %b exp 0", bus.rd_valid); end
  endtask

  task automatic test_mid_reset();
    cplx_t exp[$];
    cplx_t a, b;
    for (int k = 0; k < NS/2; k++) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, rnd(), rnd(), (k < 2), 1'b0);
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_sc !== SW'(2)) begin
      errors++; $display("FAIL mr_before got valid %b sc %0d exp 1 2", bus.rd_valid, bus.rd_sc); end
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.wr_ready !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_sc !== SW'(0) || err_ovf !== 1'b0) begin
      errors++; $display("FAIL mr_async got ready %b valid %b sc %0d ovf %b exp 1 0 0 0",
                          bus.wr_ready, bus.rd_valid, bus.rd_sc, err_ovf); end
    m_clear();
    rst = 1'b1;
    for (int k = 0; k < NS/2; k++) begin
      a = rnd(); b = rnd(); exp.push_back(a); exp.push_back(b);
      cyc(1'b1, a, b, 1'b0, 1'b0);
    end
    for (int i = 0; i < NS; i++) begin
      checks++; if (bus.rd_valid !== 1'b1 || bus.rd_sc !== SW'(i) || {bus.rd_h_r, bus.rd_h_i} !== exp[i]) begin
        errors++; $display("FAIL mr_readback sc %0d got valid %b sc %0d data %h exp 1 %0d %h",
                            i, bus.rd_valid, bus.rd_sc, {bus.rd_h_r, bus.rd_h_i}, i, exp[i]); end
      cyc(1'b0, mk(0, 0), mk(0, 0), 1'b1, 1'b0);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < NS + 1; k++) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL fl_ovf_set got %b exp 1", err_ovf); end
    for (int i = 0; i < NS; i++) cyc(1'b0, mk(0, 0), mk(0, 0), 1'b1, 1'b0);
    for (int k = 0; k < NS/2 - 1; k++) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    cyc(1'b1, rnd(), rnd(), 1'b0, 1'b1);
    checks++; if (bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1 || err_ovf !== 1'b0 || bus.rd_sc !== SW'(0)) begin
      errors++; $display("FAIL fl_busy got valid %b ready %b ovf %b sc %0d exp 0 1 0 0",
                          bus.rd_valid, bus.wr_ready, err_ovf, bus.rd_sc); end
    for (int k = 0; k < NS/2 - 1; k++) cyc(1'b1, rnd(), rnd(), 1'b0, 1'b0);
    cyc(1'b1, rnd(), rnd(), 1'b0, 1'b1);
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL fl_final_write got %b exp 0", bus.rd_valid); end
    cyc(1'b0, mk(0, 0), mk(0, 0), 1'b0, 1'b0);
    checks++; if (bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1) begin
      errors++; $display("FAIL fl_idle got valid %b ready %b exp 0 1", bus.rd_valid, bus.wr_ready); end
  endtask

  task automatic test_random();
    bit wv, rr, fl;
    cyc(1'b0, mk(0, 0), mk(0, 0), 1'b0, 1'b1);
    for (int n = 0; n < 600; n++) begin
      checks++; if (bus.wr_ready !== (nsym < 2) || bus.rd_valid !== (nsym > 0)) begin
        errors++; $display("FAIL rnd_flags cyc %0d got ready %b valid %b exp %b %b",
                            n, bus.wr_ready, bus.rd_valid, (nsym < 2), (nsym > 0)); end
      checks++; if (bus.rd_sc !== SW'(rpos) || bus.rd_last !== (nsym > 0 && rpos == NS-1)) begin
        errors++; $display("FAIL rnd_sc cyc %0d got sc %0d last %b exp %0d %b",
                            n, bus.rd_sc, bus.rd_last, rpos, (nsym > 0 && rpos == NS-1)); end
      checks++; if (err_ovf !== m_err) begin
        errors++; $display("FAIL rnd_err_ovf cyc %0d got %b exp %b", n, err_ovf, m_err); end
      if (nsym > 0) begin
        checks++; if ({bus.rd_h_r, bus.rd_h_i} !== rdq[0]) begin
          errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", n, {bus.rd_h_r, bus.rd_h_i}, rdq[0]); end
      end
      wv = ($urandom_range(99) < 70);
      rr = ($urandom_range(99) < 55);
      fl = ($urandom_range(199) == 0);
      cyc(wv, rnd(), rnd(), rr, fl);
    end
  endtask

  initial begin
    test_reset();
    test_single_symbol();
    test_backpressure();
    test_pingpong();
    test_mid_reset();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
